// File: rtl/user_io_pkg.sv
// Shared definitions for the user_io SPI link: command codes, master FSM states
// and a helper for sizing a frame.
package user_io_pkg;

  localparam logic [7:0] CMD_BUTTONS      = 8'h01;
  localparam logic [7:0] CMD_IKBD_IN      = 8'h02;
  localparam logic [7:0] CMD_IKBD_OUT     = 8'h03;
  localparam logic [7:0] CMD_JOYSTICK0    = 8'h04;
  localparam logic [7:0] CMD_JOYSTICK1    = 8'h05;
  localparam logic [7:0] CMD_MOUSE        = 8'h06;
  localparam logic [7:0] CMD_KEYBOARD     = 8'h07;
  localparam logic [7:0] CMD_KEYBOARD_OSD = 8'h08;
  localparam logic [7:0] CMD_SERIAL_IN    = 8'h09;
  localparam logic [7:0] CMD_SERIAL_OUT   = 8'h0A;
  localparam logic [7:0] CMD_MIDI_IN      = 8'h0B;
  localparam logic [7:0] CMD_MIDI_OUT     = 8'h0C;
  localparam logic [7:0] CMD_STATUS       = 8'h0D;
  localparam logic [7:0] CMD_SD_STATUS    = 8'h0E;
  localparam logic [7:0] CMD_SD_WRITE     = 8'h0F;
  localparam logic [7:0] CMD_SD_READ      = 8'h10;
  localparam logic [7:0] CMD_SD_CONF      = 8'h11;
  localparam logic [7:0] CMD_SD_INSERT    = 8'h12;
  localparam logic [7:0] CMD_CORE_TYPE    = 8'h13;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } uio_state_t;

  // Index of the final bit in a frame of one command byte plus len payload bytes.
  function automatic logic [7:0] last_bit_index(input logic [3:0] len);
    return {1'b0, len, 3'b111};
  endfunction

endpackage

// File: rtl/user_io_master_clkgen.sv
// Divider for the user_io SPI master: ticks every CLK_DIV clk cycles while running
// and splits the ticks into alternating SPI_CLK fall/rise enables.
module user_io_master_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick,
  output logic o_preTick,
  output logic o_fall,
  output logic o_rise
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;

  // The first tick after i_run rises is a fall; phase restarts whenever the link idles.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_cnt   <= RELOAD;
      r_phase <= 1'b0;
    end else if (r_cnt == 8'd0) begin
      r_cnt   <= RELOAD;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick    = i_run && (r_cnt == 8'd0);
  assign o_preTick = i_run && (r_cnt == 8'd1);
  assign o_fall    = o_tick && !r_phase;
  assign o_rise    = o_tick && r_phase;

endmodule

// File: rtl/user_io_master.sv
// SPI master for the user_io link: sends a command byte followed by up to 15 payload bytes.
// Define USER_IO_MASTER_CORE_TYPE_EN to capture the core type byte returned during the command.
module user_io_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [3:0] len,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] core_type,
  output logic       SPI_CLK,
  output logic       SPI_SS_IO,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);
  import user_io_pkg::*;

  uio_state_t r_state;
  logic [7:0] r_cmd;
  logic [3:0] r_len;
  logic [7:0] r_bit;
  logic [7:0] r_txShift;
  logic [7:0] r_rxShift;
  logic       r_byteDone;

  logic       w_run;
  logic       w_tick;
  logic       w_preTick;
  logic       w_fall;
  logic       w_rise;
  logic [7:0] w_lastBit;

  assign w_run     = (r_state != IDLE);
  assign w_lastBit = last_bit_index(r_len);

  user_io_master_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_run    (w_run),
    .o_tick   (w_tick),
    .o_preTick(w_preTick),
    .o_fall   (w_fall),
    .o_rise   (w_rise)
  );

  // r_bit advances on falls so it always names the bit currently on the wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cmd      <= 8'h00;
      r_len      <= 4'd0;
      r_bit      <= 8'd0;
      r_txShift  <= 8'h00;
      r_rxShift  <= 8'h00;
      r_byteDone <= 1'b0;
      tx_ack     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SPI_CLK    <= 1'b1;
      SPI_SS_IO  <= 1'b1;
      SPI_MOSI   <= 1'b0;
    end else begin
      tx_ack     <= 1'b0;
      rx_valid   <= 1'b0;
      done       <= 1'b0;
      r_byteDone <= 1'b0;

      if (r_byteDone && (r_bit[6:3] != 4'd0)) begin
        rx_data  <= r_rxShift;
        rx_valid <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= SETUP;
            r_cmd     <= cmd;
            r_len     <= len;
            busy      <= 1'b1;
            SPI_SS_IO <= 1'b0;
          end
        end

        SETUP: begin
          if (w_tick) begin
            r_state   <= SHIFT;
            r_bit     <= 8'd0;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= r_cmd[7];
            r_txShift <= {r_cmd[6:0], 1'b0};
          end
        end

        SHIFT: begin
          if (w_rise) begin
            SPI_CLK   <= 1'b1;
            r_rxShift <= {r_rxShift[6:0], SPI_MISO};
            if (r_bit[2:0] == 3'd7) begin
              r_byteDone <= 1'b1;
            end
          end else if (w_fall) begin
            if (r_bit == w_lastBit) begin
              r_state <= HOLD;
            end else begin
              r_bit   <= r_bit + 8'd1;
              SPI_CLK <= 1'b0;
              // A new payload byte begins: take tx_data now and acknowledge it.
              if (r_bit[2:0] == 3'd7) begin
                SPI_MOSI  <= tx_data[7];
                r_txShift <= {tx_data[6:0], 1'b0};
                tx_ack    <= 1'b1;
              end else begin
                SPI_MOSI  <= r_txShift[7];
                r_txShift <= {r_txShift[6:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (w_tick) begin
            r_state   <= GAP;
            SPI_SS_IO <= 1'b1;
            SPI_MOSI  <= 1'b0;
          end
        end

        GAP: begin
          if (w_preTick) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          if (w_tick) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef USER_IO_MASTER_CORE_TYPE_EN
  logic [7:0] r_coreType;

  // The slave answers the command byte with its core type; keep the latest answer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coreType <= 8'h00;
    end else if (r_byteDone && (r_bit[6:3] == 4'd0)) begin
      r_coreType <= r_rxShift;
    end
  end

  assign core_type = r_coreType;
`else
  assign core_type = 8'h00;
`endif

endmodule

// File: tb/tb_user_io_master.sv
// Directed bench for user_io_master with a behavioural user_io slave (CLK_DIV=4, core type 0xA4).
// Core type expectation follows USER_IO_MASTER_CORE_TYPE_EN.
module tb_user_io_master;

  localparam int         CLK_DIV   = 4;
  localparam logic [7:0] CORE_TYPE = 8'hA4;
`ifdef USER_IO_MASTER_CORE_TYPE_EN
  localparam logic [7:0] EXP_CORE = CORE_TYPE;
`else
  localparam logic [7:0] EXP_CORE = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [3:0] len = 4'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic [7:0] core_type;
  logic       SPI_CLK;
  logic       SPI_SS_IO;
  logic       SPI_MOSI;
  logic       SPI_MISO = 1'b0;

  int nVec = 0;
  int nMiss = 0;

  // Slave state
  logic [7:0] slvTx [17];
  logic [7:0] slvRx [17];
  int         slvBits = 0;
  int         slvRxCnt = 0;
  logic [7:0] slvShift = 8'h00;
  logic [7:0] slvByte;
  logic [2:0] slvBitSel;

  // Transaction runner results
  logic [7:0] txBytes [17];
  logic [7:0] runRxData [16];
  int         runAck, runRx, runDone, runCycles, runTimeout;
  logic       runBusyStart, runSsStart, runBusyDone;
  logic [7:0] runCore;

  user_io_master #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cmd      (cmd),
    .len      (len),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .core_type(core_type),
    .SPI_CLK  (SPI_CLK),
    .SPI_SS_IO(SPI_SS_IO),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO)
  );

  always #5 clk = ~clk;

  // Behavioural user_io slave: MISO changes on SCK fall, MOSI sampled on SCK rise.
  always begin
    @(negedge SPI_SS_IO);
    slvBits  = 0;
    slvRxCnt = 0;
    while (SPI_SS_IO === 1'b0) begin
      @(SPI_CLK or SPI_SS_IO);
      if (SPI_SS_IO !== 1'b0) break;
      if (SPI_CLK === 1'b0) begin
        slvByte   = (slvBits < 136) ? slvTx[slvBits / 8] : 8'h00;
        slvBitSel = 3'(7 - (slvBits % 8));
        SPI_MISO  = slvByte[slvBitSel];
      end else begin
        slvShift = {slvShift[6:0], SPI_MOSI};
        slvBits++;
        if ((slvBits % 8 == 0) && (slvRxCnt < 17)) begin
          slvRx[slvRxCnt] = slvShift;
          slvRxCnt++;
        end
      end
    end
  end

  task automatic setSlave(input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 17; i++) slvTx[i] = 8'h00;
    slvTx[0] = CORE_TYPE;
    slvTx[1] = b1;
    slvTx[2] = b2;
  endtask

  // Drives one transaction from a negedge and records what the master reports.
  task automatic runTxn(input logic [7:0] c, input logic [3:0] l, input int cap);
    runAck = 0; runRx = 0; runDone = 0; runCycles = -1; runTimeout = 0;
    runBusyDone = 1'bx;
    cmd = c; len = l; tx_data = txBytes[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runBusyStart = busy;
    runSsStart   = SPI_SS_IO;
    for (int cyc = 0; cyc < cap; cyc++) begin
      if (tx_ack) begin
        runAck++;
        tx_data = txBytes[(runAck > 16) ? 16 : runAck];
      end
      if (rx_valid) begin
        if (runRx < 16) runRxData[runRx] = rx_data;
        runRx++;
      end
      if (done) begin
        runDone++;
        runBusyDone = busy;
        runCycles = cyc;
        break;
      end
      @(negedge clk);
    end
    if (runCycles < 0) runTimeout = 1;
    repeat (3 * CLK_DIV) begin
      @(negedge clk);
      if (done) runDone++;
      if (tx_ack) runAck++;
      if (rx_valid) runRx++;
    end
    runCore = core_type;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nVec++; if (SPI_SS_IO !== 1'b1) begin nMiss++; $display("[TB] FAIL reset_ss: got %b want 1", SPI_SS_IO); end
    nVec++; if (SPI_CLK !== 1'b1) begin nMiss++; $display("[TB] FAIL reset_sck: got %b want 1", SPI_CLK); end
    nVec++; if (SPI_MOSI !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_mosi: got %b want 0", SPI_MOSI); end
    nVec++; if ({busy, done, tx_ack, rx_valid} !== 4'b0000) begin nMiss++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy, done, tx_ack, rx_valid}); end
    nVec++; if (rx_data !== 8'h00) begin nMiss++; $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data); end
    nVec++; if (core_type !== 8'h00) begin nMiss++; $display("[TB] FAIL reset_core_type: got %h want 00", core_type); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_buttons();
    setSlave(8'h77, 8'h00);
    txBytes[0] = 8'h35;
    runTxn(8'h01, 4'd1, 400);
    nVec++; if (runTimeout !== 0) begin nMiss++; $display("[TB] FAIL btn_timeout: got %0d want 0", runTimeout); end
    nVec++; if ({runBusyStart, runSsStart} !== 2'b10) begin nMiss++; $display("[TB] FAIL btn_start_busy_ss: got %b want 10", {runBusyStart, runSsStart}); end
    nVec++; if (slvRxCnt !== 2) begin nMiss++; $display("[TB] FAIL btn_slave_bytes: got %0d want 2", slvRxCnt); end
    nVec++; if ({slvRx[0], slvRx[1]} !== 16'h0135) begin nMiss++; $display("[TB] FAIL btn_slave_data: got %h want 0135", {slvRx[0], slvRx[1]}); end
    nVec++; if (runAck !== 1) begin nMiss++; $display("[TB] FAIL btn_tx_ack_count: got %0d want 1", runAck); end
    nVec++; if (runRx !== 1) begin nMiss++; $display("[TB] FAIL btn_rx_valid_count: got %0d want 1", runRx); end
    nVec++; if (runRxData[0] !== 8'h77) begin nMiss++; $display("[TB] FAIL btn_rx_data: got %h want 77", runRxData[0]); end
    nVec++; if (runDone !== 1) begin nMiss++; $display("[TB] FAIL btn_done_count: got %0d want 1", runDone); end
    nVec++; if (runCycles !== 139) begin nMiss++; $display("[TB] FAIL btn_done_latency: got %0d want 139", runCycles); end
    nVec++; if (runBusyDone !== 1'b0) begin nMiss++; $display("[TB] FAIL btn_busy_at_done: got %b want 0", runBusyDone); end
    nVec++; if (runCore !== EXP_CORE) begin nMiss++; $display("[TB] FAIL btn_core_type: got %h want %h", runCore, EXP_CORE); end
  endtask

  task automatic test_ikbd_out();
    setSlave(8'h01, 8'h5A);
    txBytes[0] = 8'h11;
    txBytes[1] = 8'h22;
    runTxn(8'h03, 4'd2, 600);
    nVec++; if (runTimeout !== 0) begin nMiss++; $display("[TB] FAIL ikbd_timeout: got %0d want 0", runTimeout); end
    nVec++; if (runRx !== 2) begin nMiss++; $display("[TB] FAIL ikbd_rx_valid_count: got %0d want 2", runRx); end
    nVec++; if ({runRxData[0], runRxData[1]} !== 16'h015A) begin nMiss++; $display("[TB] FAIL ikbd_rx_data: got %h want 015a", {runRxData[0], runRxData[1]}); end
    nVec++; if (slvBits !== 24) begin nMiss++; $display("[TB] FAIL ikbd_sck_rises: got %0d want 24", slvBits); end
    nVec++; if ({slvRx[0], slvRx[1], slvRx[2]} !== 24'h031122) begin nMiss++; $display("[TB] FAIL ikbd_slave_data: got %h want 031122", {slvRx[0], slvRx[1], slvRx[2]}); end
    nVec++; if (runAck !== 2) begin nMiss++; $display("[TB] FAIL ikbd_tx_ack_count: got %0d want 2", runAck); end
    nVec++; if (runCycles !== 203) begin nMiss++; $display("[TB] FAIL ikbd_done_latency: got %0d want 203", runCycles); end
  endtask

  task automatic test_len_zero();
    setSlave(8'hFF, 8'hFF);
    txBytes[0] = 8'hC3;
    runTxn(8'h10, 4'd0, 300);
    nVec++; if (slvBits !== 8) begin nMiss++; $display("[TB] FAIL len0_sck_pulses: got %0d want 8", slvBits); end
    nVec++; if (slvRx[0] !== 8'h10) begin nMiss++; $display("[TB] FAIL len0_slave_cmd: got %h want 10", slvRx[0]); end
    nVec++; if ({runAck, runRx} !== {32'd0, 32'd0}) begin nMiss++; $display("[TB] FAIL len0_ack_rx: got ack %0d rx %0d want 0 0", runAck, runRx); end
    nVec++; if (runDone !== 1) begin nMiss++; $display("[TB] FAIL len0_done_count: got %0d want 1", runDone); end
    nVec++; if (runCycles !== 75) begin nMiss++; $display("[TB] FAIL len0_done_latency: got %0d want 75", runCycles); end
  endtask

  task automatic test_back_to_back();
    int seen;
    setSlave(8'h00, 8'h00);
    seen = -1;
    cmd = 8'h02; len = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc == 20) begin start = 1'b1; cmd = 8'h07; len = 4'd5; end
      if (cyc == 21) start = 1'b0;
      if (done) begin seen = cyc; break; end
      @(negedge clk);
    end
    nVec++; if (seen !== 75) begin nMiss++; $display("[TB] FAIL b2b_busy_start_ignored: done at %0d want 75", seen); end
    nVec++; if ({slvBits, 24'(slvRx[0])} !== {32'd8, 24'h000002}) begin nMiss++; $display("[TB] FAIL b2b_cmd_unchanged: got bits %0d byte %h want 8 02", slvBits, slvRx[0]); end
    start = 1'b1; cmd = 8'h05;
    @(negedge clk);
    start = 1'b0;
    nVec++; if ({busy, SPI_SS_IO} !== 2'b01) begin nMiss++; $display("[TB] FAIL b2b_start_at_done: got busy/ss %b want 01", {busy, SPI_SS_IO}); end
    start = 1'b1; cmd = 8'h06; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    nVec++; if ({busy, SPI_SS_IO} !== 2'b10) begin nMiss++; $display("[TB] FAIL b2b_start_after_done: got busy/ss %b want 10", {busy, SPI_SS_IO}); end
    seen = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin seen = cyc; break; end
      @(negedge clk);
    end
    nVec++; if ({seen, 24'(slvRx[0])} !== {32'd75, 24'h000006}) begin nMiss++; $display("[TB] FAIL b2b_second_txn: done at %0d byte %h want 75 06", seen, slvRx[0]); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int doneCnt;
    int waited;
    setSlave(8'h12, 8'h34);
    txBytes[0] = 8'hFF; txBytes[1] = 8'hFF; txBytes[2] = 8'hFF;
    cmd = 8'h04; len = 4'd3; tx_data = txBytes[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while ((slvBits < 11) && (waited < 500)) begin
      @(negedge clk);
      waited++;
    end
    nVec++; if (slvBits !== 11) begin nMiss++; $display("[TB] FAIL abort_reach_11_bits: got %0d want 11", slvBits); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nVec++; if ({SPI_SS_IO, SPI_CLK, SPI_MOSI, busy} !== 4'b1100) begin nMiss++; $display("[TB] FAIL abort_outputs: got ss/sck/mosi/busy %b want 1100", {SPI_SS_IO, SPI_CLK, SPI_MOSI, busy}); end
    nVec++; if ({tx_ack, rx_valid, core_type} !== 10'h000) begin nMiss++; $display("[TB] FAIL abort_flags_core: got %h want 000", {tx_ack, rx_valid, core_type}); end
    doneCnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    nVec++; if (doneCnt !== 0) begin nMiss++; $display("[TB] FAIL abort_no_done: got %0d want 0", doneCnt); end
    setSlave(8'h3C, 8'h00);
    txBytes[0] = 8'h35;
    runTxn(8'h01, 4'd1, 400);
    nVec++; if ({runDone, runCycles} !== {32'd1, 32'd139}) begin nMiss++; $display("[TB] FAIL abort_recover_done: got %0d at %0d want 1 at 139", runDone, runCycles); end
    nVec++; if ({slvRx[0], slvRx[1], runRxData[0]} !== 24'h01353C) begin nMiss++; $display("[TB] FAIL abort_recover_data: got %h want 01353c", {slvRx[0], slvRx[1], runRxData[0]}); end
  endtask

  initial begin
    for (int i = 0; i < 17; i++) txBytes[i] = 8'h00;
    setSlave(8'h00, 8'h00);
    test_reset();
    test_buttons();
    test_ikbd_out();
    test_len_zero();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
